// File: rtl/slave_resp_router_if.sv
// Bundle of arbiter, slave-response and routed master-side signals for slave_resp_router.
// The router uses the slave modport; the environment that drives it uses the master modport.
interface slave_resp_router_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned N_SLAVES  = 3
);
    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic [N_MASTERS-1:0] bus_grant;
    logic [SEL_W-1:0]     slave_sel;
    logic                 slave_sel_vld;

    logic [N_SLAVES-1:0]  s_valid;
    logic [N_SLAVES-1:0]  s_ready;
    logic [N_SLAVES-1:0]  s_tx_done;
    logic [N_SLAVES-1:0]  s_rx_done;
    logic [N_SLAVES-1:0]  s_tx_data;

    logic [N_MASTERS-1:0] m_valid;
    logic [N_MASTERS-1:0] m_ready;
    logic [N_MASTERS-1:0] m_tx_done;
    logic [N_MASTERS-1:0] m_rx_done;
    logic [N_MASTERS-1:0] m_tx_data;

    logic                 busy;
    logic                 route_err;
    logic                 timeout_err;

    modport slave (
        input  bus_grant, slave_sel, slave_sel_vld,
        input  s_valid, s_ready, s_tx_done, s_rx_done, s_tx_data,
        output m_valid, m_ready, m_tx_done, m_rx_done, m_tx_data,
        output busy, route_err, timeout_err
    );

    modport master (
        output bus_grant, slave_sel, slave_sel_vld,
        output s_valid, s_ready, s_tx_done, s_rx_done, s_tx_data,
        input  m_valid, m_ready, m_tx_done, m_rx_done, m_tx_data,
        input  busy, route_err, timeout_err
    );
endinterface

// File: rtl/slave_resp_router.sv
// Routes one slave's response signals to the granted master for the life of a transfer.
// Error flags are registered: each pulses in the cycle after its triggering condition.
module slave_resp_router #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned N_SLAVES  = 3,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned REG_OUT   = 0
) (
    input  logic               clk,
    input  logic               rstn,
    slave_resp_router_if.slave bus
);
    localparam int unsigned MST_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [MST_W-1:0] mst_q, mst_d;
    logic [SEL_W-1:0] slv_q, slv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             route_err_q, route_err_d;
    logic             timeout_err_q, timeout_err_d;

    logic             grant_onehot;
    logic [MST_W-1:0] grant_idx;
    logic             sel_ok;

    logic sel_valid, sel_ready, sel_tx_done, sel_rx_done, sel_tx_data;
    logic activity, done, abort, tmo;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (bus.bus_grant[i]) grant_idx = MST_W'(i);
        end
    end

    assign grant_onehot = (bus.bus_grant != '0) &&
                          ((bus.bus_grant & (bus.bus_grant - 1'b1)) == '0);
    assign sel_ok       = {1'b0, bus.slave_sel} < (SEL_W + 1)'(N_SLAVES);

    assign sel_valid   = bus.s_valid[slv_q];
    assign sel_ready   = bus.s_ready[slv_q];
    assign sel_tx_done = bus.s_tx_done[slv_q];
    assign sel_rx_done = bus.s_rx_done[slv_q];
    assign sel_tx_data = bus.s_tx_data[slv_q];

    assign activity = sel_valid | sel_ready | sel_tx_done | sel_rx_done | sel_tx_data;
    assign done     = sel_tx_done | sel_rx_done;
    assign abort    = ~bus.bus_grant[mst_q];
    assign tmo      = (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        mst_d         = mst_q;
        slv_d         = slv_q;
        cnt_d         = cnt_q;
        route_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.slave_sel_vld) begin
                    if (grant_onehot && sel_ok) begin
                        state_d = ACTIVE;
                        mst_d   = grant_idx;
                        slv_d   = bus.slave_sel;
                    end else begin
                        route_err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (activity) begin
                    cnt_d = '0;
                end else if (!tmo) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Done/abort take precedence so timeout_err only flags a genuine stall.
                if (done || abort) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            mst_q         <= '0;
            slv_q         <= '0;
            cnt_q         <= '0;
            route_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mst_q         <= mst_d;
            slv_q         <= slv_d;
            cnt_q         <= cnt_d;
            route_err_q   <= route_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    logic [N_MASTERS-1:0] m_valid_c, m_ready_c, m_tx_done_c, m_rx_done_c, m_tx_data_c;

    always_comb begin
        m_valid_c   = '0;
        m_ready_c   = '0;
        m_tx_done_c = '0;
        m_rx_done_c = '0;
        m_tx_data_c = '0;
        if (state_q == ACTIVE) begin
            m_valid_c[mst_q]   = sel_valid;
            m_ready_c[mst_q]   = sel_ready;
            m_tx_done_c[mst_q] = sel_tx_done;
            m_rx_done_c[mst_q] = sel_rx_done;
            m_tx_data_c[mst_q] = sel_tx_data;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [N_MASTERS-1:0] m_valid_q, m_ready_q, m_tx_done_q, m_rx_done_q, m_tx_data_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    m_valid_q   <= '0;
                    m_ready_q   <= '0;
                    m_tx_done_q <= '0;
                    m_rx_done_q <= '0;
                    m_tx_data_q <= '0;
                end else begin
                    m_valid_q   <= m_valid_c;
                    m_ready_q   <= m_ready_c;
                    m_tx_done_q <= m_tx_done_c;
                    m_rx_done_q <= m_rx_done_c;
                    m_tx_data_q <= m_tx_data_c;
                end
            end

            assign bus.m_valid   = m_valid_q;
            assign bus.m_ready   = m_ready_q;
            assign bus.m_tx_done = m_tx_done_q;
            assign bus.m_rx_done = m_rx_done_q;
            assign bus.m_tx_data = m_tx_data_q;
        end else begin : g_comb_out
            assign bus.m_valid   = m_valid_c;
            assign bus.m_ready   = m_ready_c;
            assign bus.m_tx_done = m_tx_done_c;
            assign bus.m_rx_done = m_rx_done_c;
            assign bus.m_tx_data = m_tx_data_c;
        end
    endgenerate

    assign bus.busy        = (state_q == ACTIVE);
    assign bus.route_err   = route_err_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
